// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> imem write port.
// Optional trailing XOR checksum byte via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_ready_o,
    output logic             imem_we_o,
    output logic [AW-1:0]    imem_waddr_o,
    output logic [WIDTH-1:0] imem_wdata_o,
    output logic             cpu_hold_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [7:0]       len_lo;
    logic [15:0]      len_q;
    logic [15:0]      len_n;
    logic [1:0]       byte_cnt;
    logic [WIDTH-1:0] word_buf;
    logic [WIDTH-1:0] word_nxt;
    logic [AW-1:0]    word_cnt;
    logic             accept;
    logic             restart;
    logic             last_word;
    logic             ready_n;
    logic             done_n;
    logic             err_n;
    logic             hold_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = rx_valid_i && rx_ready_o;
    assign restart   = start_i && (state == IDLE || state == DONE);
    assign len_n     = {rx_data_i, len_lo};
    assign last_word = (32'(word_cnt) == 32'(len_q) - 32'd1);

    always_comb begin
        word_nxt = word_buf;
        word_nxt[{byte_cnt, 3'b000} +: 8] = rx_data_i;
    end

    always_comb begin
        state_n = state;
        done_n  = done_o;
        err_n   = err_o;
        hold_n  = cpu_hold_o;
        unique case (state)
            IDLE: if (start_i) state_n = LEN0;
            LEN0: if (accept) state_n = LEN1;
            LEN1: if (accept) begin
                if (len_n == 16'd0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b0;
                    hold_n  = 1'b0;
                end else if (32'(len_n) > DEPTH) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    hold_n  = 1'b1;
                end else begin
                    state_n = DATA;
                end
            end
            DATA: if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_n = CHK;
`else
                state_n = DONE;
                done_n  = 1'b1;
                err_n   = 1'b0;
                hold_n  = 1'b0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (accept) begin
                state_n = DONE;
                done_n  = 1'b1;
                err_n   = (rx_data_i != csum);
                hold_n  = (rx_data_i != csum);
            end
`endif
            DONE: if (start_i) begin
                state_n = LEN0;
                done_n  = 1'b0;
                err_n   = 1'b0;
                hold_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_n = (state_n == LEN0) || (state_n == LEN1) ||
                  (state_n == DATA) || (state_n == CHK);
`else
        ready_n = (state_n == LEN0) || (state_n == LEN1) ||
                  (state_n == DATA);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_ready_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            cpu_hold_o   <= 1'b1;
            imem_we_o    <= 1'b0;
            imem_waddr_o <= '0;
            imem_wdata_o <= '0;
            len_lo       <= '0;
            len_q        <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
            word_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state      <= state_n;
            rx_ready_o <= ready_n;
            busy_o     <= ready_n;
            done_o     <= done_n;
            err_o      <= err_n;
            cpu_hold_o <= hold_n;
            imem_we_o  <= 1'b0;
            if (restart) begin
                byte_cnt <= '0;
                word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == LEN0 && accept) len_lo <= rx_data_i;
            if (state == LEN1 && accept) len_q <= len_n;
            // Write issues the cycle after the 4th byte, using the merged word.
            if (state == DATA && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data_i;
`endif
                if (byte_cnt == 2'd3) begin
                    imem_we_o    <= 1'b1;
                    imem_waddr_o <= word_cnt;
                    imem_wdata_o <= word_nxt;
                    word_cnt     <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; covers checksum mode when
// IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             rx_valid_i = 1'b0;
    logic [7:0]       rx_data_i = 8'h00;
    logic             rx_ready_o;
    logic             imem_we_o;
    logic [AW-1:0]    imem_waddr_o;
    logic [WIDTH-1:0] imem_wdata_o;
    logic             cpu_hold_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .rx_ready_o(rx_ready_o), .imem_we_o(imem_we_o),
        .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nwr = 0;
    int stalls = 0;
    int last_addr = -1;
    logic [31:0] prog[$];
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: every write must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (imem_we_o === 1'b1) begin
            nwr++;
            last_addr = int'(imem_waddr_o);
            if (exp_addr.size() == 0) begin
                chk("unexp_we", 32'd1, 32'd0);
            end else begin
                chk("waddr", 32'(imem_waddr_o), exp_addr.pop_front());
                chk("wdata", imem_wdata_o, exp_data.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit last4);
        int n;
        rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        n = 0;
        while (!rx_ready_o && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            chk("rdy_to", 32'd0, 32'd1);
            rx_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid_i = 1'b0;
        if (last4) chk("lat", 32'(imem_we_o), 32'd1);
    endtask

    function automatic int pick_gap(input int gmax);
        return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    endfunction

    task automatic load(input int gmax);
        logic [15:0] nn;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        nn = 16'(prog.size());
        x  = 8'h00;
        send_byte(nn[7:0], pick_gap(gmax), 1'b0);
        send_byte(nn[15:8], pick_gap(gmax), 1'b0);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                x ^= b;
                if (k == 3) begin
                    exp_addr.push_back(i);
                    exp_data.push_back(w);
                end
                send_byte(b, pick_gap(gmax), k == 3);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, pick_gap(gmax), 1'b0);
`endif
    endtask

    task automatic start_session;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!done_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("done_to", 32'd0, 32'd1);
    endtask

    task automatic expect_done(input string tag, input logic err,
                               input logic hold);
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'(err));
        chk({tag, "_hold"}, 32'(cpu_hold_o), 32'(hold));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_rdy"}, 32'(rx_ready_o), 32'd0);
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", 32'(cpu_hold_o), 32'd1);
        chk("rst_rdy", 32'(rx_ready_o), 32'd0);
        chk("rst_we", 32'(imem_we_o), 32'd0);
        chk("rst_waddr", 32'(imem_waddr_o), 32'd0);
        chk("rst_wdata", imem_wdata_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;

        rx_valid_i = 1'b1;
        rx_data_i  = 8'h55;
        repeat (3) @(negedge clk);
        chk("idle_rdy", 32'(rx_ready_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        rx_valid_i = 1'b0;

        prog = '{32'h00000013, 32'h00100093};
        start_session();
        chk("start_busy", 32'(busy_o), 32'd1);
        load(0);
        wait_done();
        expect_done("norm", 1'b0, 1'b0);
        chk("norm_nwr", 32'(nwr), 32'd2);

        start_session();
        chk("rs_done", 32'(done_o), 32'd0);
        chk("rs_hold", 32'(cpu_hold_o), 32'd1);
        chk("rs_busy", 32'(busy_o), 32'd1);
        w0 = nwr;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        wait_done();
        expect_done("n0", 1'b0, 1'b0);
        chk("n0_nwr", 32'(nwr), 32'(w0));

        start_session();
        send_byte(8'h2C, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        wait_done();
        expect_done("n300", 1'b1, 1'b1);
        chk("n300_nwr", 32'(nwr), 32'(w0));

        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
        start_session();
        stalls = 0;
        w0 = nwr;
        load(0);
        wait_done();
        expect_done("n256", 1'b0, 1'b0);
        chk("n256_nwr", 32'(nwr - w0), 32'd256);
        chk("n256_last", 32'(last_addr), 32'd255);
        chk("n256_stall", 32'(stalls), 32'd0);

        prog = '{32'h00000013, 32'h00100093};
        start_session();
        load(3);
        wait_done();
        expect_done("gaps", 1'b0, 1'b0);

        start_session();
        w0 = nwr;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", 32'(busy_o), 32'd0);
        chk("mr_rdy", 32'(rx_ready_o), 32'd0);
        chk("mr_hold", 32'(cpu_hold_o), 32'd1);
        chk("mr_done", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("mr_nwr", 32'(nwr), 32'(w0));
        prog = '{32'hDEADBEEF, 32'h00A00513};
        start_session();
        load(2);
        wait_done();
        expect_done("mr_load", 1'b0, 1'b0);
        chk("mr_load_nwr", 32'(nwr - w0), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            start_session();
            w0 = nwr;
            send_byte(8'h01, 0, 1'b0);
            send_byte(8'h00, 0, 1'b0);
            exp_addr.push_back(0);
            exp_data.push_back(32'h00000013);
            send_byte(8'h13, 0, 1'b0);
            send_byte(8'h00, 0, 1'b0);
            send_byte(8'h00, 0, 1'b0);
            send_byte(8'h00, 0, 1'b1);
            chk("cs_inchk", 32'(busy_o), 32'd1);
            send_byte((t == 0) ? 8'h13 : 8'h12, 0, 1'b0);
            wait_done();
            if (t == 0) expect_done("cs_ok", 1'b0, 1'b0);
            else expect_done("cs_bad", 1'b1, 1'b1);
            chk("cs_nwr", 32'(nwr - w0), 32'd1);
        end
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_addr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. Receives a byte stream over a valid/ready interface, assembles little-endian 32-bit instructions and drives a word-indexed write port into the instruction ROM array.
- Holds the core in reset until a program has been loaded successfully.
- Sits between the host/UART byte receiver and the write side of imem. Fetch reads the same array through the PC-addressed port.

Parameters:
- WIDTH, 32 (from all_pkgs), instruction word width.
- DEPTH, 256, number of instruction words in imem.
- AW, $clog2(DEPTH), width of the word index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a load session; sampled only in IDLE or DONE.
- rx_valid_i  in  1  byte available.
- rx_data_i  in  8  byte value.
- rx_ready_o  out  1  loader can accept a byte.
- imem_we_o  out  1  one-cycle write strobe.
- imem_waddr_o  out  AW  word index; byte address = index*4.
- imem_wdata_o  out  WIDTH  instruction word.
- cpu_hold_o  out  1  holds the core in reset.
- busy_o  out  1  load in progress.
- done_o  out  1  session finished.
- err_o  out  1  session failed.

Behaviour:
- One clock domain. Reset is synchronous and active-high: ports clk and rst.
- All outputs are registered.
- Reset values: rx_ready_o=0, imem_we_o=0, imem_waddr_o=0, imem_wdata_o=0, cpu_hold_o=1, busy_o=0, done_o=0, err_o=0. State = IDLE.
- Handshake: a byte is consumed only when rx_valid_i && rx_ready_o. rx_valid_i while rx_ready_o=0 is ignored and not consumed.
- rx_ready_o=1 exactly in LEN0, LEN1, DATA and CHK.
- busy_o=1 in the same states.
- FSM states: IDLE, LEN0, LEN1, DATA, CHK (feature only), DONE.
- IDLE: start_i -> LEN0.
- LEN0/LEN1: receive a 16-bit word count N, low byte first.
  - After LEN1, N==0 -> DONE with err_o=0 and no writes.
  - After LEN1, N>DEPTH -> DONE with err_o=1 and no writes.
  - Otherwise -> DATA.
- DATA byte assembly:
  - A 2-bit byte counter places the byte into [8k+7:8k].
  - On the 4th accepted byte, the next cycle drives imem_we_o=1 for exactly one cycle, with imem_wdata_o = the assembled word and imem_waddr_o = word_cnt.
  - word_cnt then increments; it starts at 0 each session.
  - Latency is 1 cycle from the 4th-byte handshake to the write strobe.
- DATA exit: after the byte completing word N-1 is accepted, the FSM goes to CHK (feature) or DONE. The final write strobe still occurs in the following cycle.
- DONE:
  - done_o=1.
  - cpu_hold_o=0 only if err_o=0; otherwise cpu_hold_o stays 1.
  - start_i restarts the session: clears done_o and err_o, sets cpu_hold_o=1, goes to LEN0.
- start_i in any other state is ignored.
- word_cnt never exceeds DEPTH-1 at a write, which the N check guarantees.
- Reset mid-load: return to IDLE next edge with reset values. The partial word is discarded and no write strobe is issued. Words already written stay in imem.
- Back-to-back bytes every cycle must be sustained; there is no throughput bubble.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers all DATA bytes; length bytes are excluded. It clears on session start.
  - After the last data byte the FSM enters CHK and accepts one byte.
  - Match -> DONE with err_o=0.
  - Mismatch -> DONE with err_o=1 and cpu_hold_o=1. Words already written are not reverted.
  - N==0 skips CHK.
- Undefined: no CHK state and no XOR logic. DATA goes straight to DONE.

Test Plan:
- Reset: hold rst 2 cycles -> cpu_hold_o=1, all other outputs 0. rx_valid_i=1 with 0x55 during IDLE is not consumed.
- Normal load: start_i, bytes 02 00, 13 00 00 00, 93 00 10 00 -> two strobes: (waddr 0, 0x00000013) and (waddr 1, 0x00100093). Each strobe is 1 cycle after its 4th byte. Then done_o=1, cpu_hold_o=0, err_o=0.
- Boundaries:
  - N=0 (00 00) -> DONE, no imem_we_o, cpu_hold_o=0.
  - N=300 (2C 01) -> err_o=1, done_o=1, no writes, cpu_hold_o=1.
  - N=256 with 1024 bytes -> last write at waddr 255.
- Stalls and reset: random rx_valid_i gaps give identical writes to the normal-load case. Assert rst after 2 data bytes -> IDLE, no strobe. A following full load writes correct words starting at waddr 0.
- Checksum (IMEM_LOADER_CHECKSUM_EN): N=1, bytes 13 00 00 00.
  - Checksum 0x13 -> err_o=0, cpu_hold_o=0.
  - Checksum 0x12 -> err_o=1, cpu_hold_o=1, but the word at waddr 0 is still written.
